// File: rtl/inst_fifo.sv
// First-word-fall-through instruction FIFO feeding decode_block, with sticky overflow/underflow flags.
// Optional almost_full output is enabled by defining INST_FIFO_ALMOST_FULL_EN.
module inst_fifo #(
    parameter int DATA_W    = 82,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write_en,
    input  logic [DATA_W-1:0]          write_data,
    input  logic                       read_en,
    output logic [DATA_W-1:0]          fifo_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clear_err
`ifdef INST_FIFO_ALMOST_FULL_EN
    ,output logic                      almost_full
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    if (DEPTH < 2 || AF_MARGIN < 0 || AF_MARGIN > DEPTH) begin : g_param_check
        $error("inst_fifo: illegal DEPTH/AF_MARGIN combination");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // A push into a full FIFO is still legal when the head leaves on the same edge.
    assign push = write_en && (!full || read_en);
    assign pop  = read_en && !empty;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = clear_err ? 1'b0 : overflow_q;
        underflow_d = clear_err ? 1'b0 : underflow_q;

        if (push) wptr_d = (wptr_q == LAST_P) ? '0 : wptr_q + 1'b1;
        if (pop)  rptr_d = (rptr_q == LAST_P) ? '0 : rptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A fresh error in the same cycle as clear_err wins.
        if (write_en && full && !read_en) overflow_d  = 1'b1;
        if (read_en && empty)             underflow_d = 1'b1;
    end

    // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; stale words are masked because fifo_data reads zero while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= write_data;
    end

    assign fifo_data = empty ? '0 : mem[rptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef INST_FIFO_ALMOST_FULL_EN
    assign almost_full = (count_q >= CW'(DEPTH - AF_MARGIN));
`endif

endmodule

// File: tb/tb_inst_fifo.sv
// Self-checking bench for inst_fifo (DEPTH=8): table-driven vectors plus hand sequences.
// Also exercises almost_full when INST_FIFO_ALMOST_FULL_EN is defined.
module tb_inst_fifo;

    localparam int DATA_W = 82;
    localparam int DEPTH  = 8;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              write_en;
    logic [DATA_W-1:0] write_data;
    logic              read_en;
    logic              clear_err;
    logic [DATA_W-1:0] fifo_data;
    logic              empty, full, overflow, underflow;
    logic [CW-1:0]     count;
`ifdef INST_FIFO_ALMOST_FULL_EN
    logic              almost_full;
`endif

    int total = 0;
    int bad   = 0;

    inst_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_MARGIN(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .write_data (write_data),
        .read_en    (read_en),
        .fifo_data  (fifo_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow),
        .clear_err  (clear_err)
`ifdef INST_FIFO_ALMOST_FULL_EN
        ,.almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [DATA_W-1:0] wd;
        logic              re;
        logic              clr;
        logic [DATA_W-1:0] exp_data;
        int                exp_count;
        logic              exp_empty;
        logic              exp_full;
        logic              exp_ovf;
        logic              exp_unf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [DATA_W-1:0] wd, logic re, logic clr,
                                logic [DATA_W-1:0] d, int c, logic e, logic f, logic o, logic u);
        vec_t v;
        v.we = we; v.wd = wd; v.re = re; v.clr = clr;
        v.exp_data = d; v.exp_count = c; v.exp_empty = e; v.exp_full = f;
        v.exp_ovf = o; v.exp_unf = u;
        return v;
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [DATA_W-1:0] wd, input logic re, input logic clr);
        @(negedge clk);
        write_en = we; write_data = wd; read_en = re; clear_err = clr;
        @(posedge clk);
        #1;
        write_en = 1'b0; read_en = 1'b0; clear_err = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " data"},  fifo_data, '0);
        check({tag, " count"}, DATA_W'(count), '0);
        check({tag, " empty"}, DATA_W'(empty), 1);
        check({tag, " full"},  DATA_W'(full), 0);
    endtask

    initial begin
        rst = 1'b1; write_en = 1'b0; write_data = '0; read_en = 1'b0; clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset ovf", DATA_W'(overflow), 0);
        check("reset unf", DATA_W'(underflow), 0);
        @(negedge clk);
        rst = 1'b0;

        // Fill 1..8, overflow, clear, full push+pop, drain, then empty-boundary cases.
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(1, DATA_W'(k), 0, 0, 1, k, 0, k == 8, 0, 0));
        vecs.push_back(mk(1, 'hAA, 0, 0, 1, 8, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 8, 0, 1, 0, 0));
        vecs.push_back(mk(1, 9, 1, 0, 2, 8, 0, 1, 0, 0));
        for (int k = 1; k <= 7; k++)
            vecs.push_back(mk(0, 0, 1, 0, DATA_W'(k + 2), 8 - k, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 5, 1, 0, 5, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].clr);
            check($sformatf("v%0d data", i),  fifo_data, vecs[i].exp_data);
            check($sformatf("v%0d count", i), DATA_W'(count), DATA_W'(vecs[i].exp_count));
            check($sformatf("v%0d empty", i), DATA_W'(empty), DATA_W'(vecs[i].exp_empty));
            check($sformatf("v%0d full", i),  DATA_W'(full), DATA_W'(vecs[i].exp_full));
            check($sformatf("v%0d ovf", i),   DATA_W'(overflow), DATA_W'(vecs[i].exp_ovf));
            check($sformatf("v%0d unf", i),   DATA_W'(underflow), DATA_W'(vecs[i].exp_unf));
        end

        // Wrap: keep three entries in flight while streaming 20 push+pop cycles.
        for (int k = 0; k < 3; k++) drive(1, DATA_W'(100 + k), 0, 0);
        check("wrap pre head", fifo_data, 100);
        for (int k = 0; k < 20; k++) begin
            drive(1, DATA_W'(103 + k), 1, 0);
            check($sformatf("wrap%0d head", k), fifo_data, DATA_W'(101 + k));
            check($sformatf("wrap%0d count", k), DATA_W'(count), 3);
        end
        drive(0, 0, 1, 0);
        check("drain0 head", fifo_data, 121);
        drive(0, 0, 1, 0);
        check("drain1 head", fifo_data, 122);
        drive(0, 0, 1, 0);
        check_idle("drained");
        check("drained unf", DATA_W'(underflow), 0);

`ifdef INST_FIFO_ALMOST_FULL_EN
        for (int k = 1; k <= 6; k++) begin
            drive(1, DATA_W'(k), 0, 0);
            if (k >= 5)
                check($sformatf("af count%0d", k), DATA_W'(almost_full), DATA_W'(k == 6));
        end
`else
        for (int k = 1; k <= 6; k++) drive(1, DATA_W'(k), 0, 0);
`endif

        // Asynchronous reset mid-cycle must clear state without a clock edge.
        drive(1, 'hAA, 0, 0);
        check("pre-rst count", DATA_W'(count), 7);
        #3;
        rst = 1'b1;
        #1;
        check_idle("async rst");
`ifdef INST_FIFO_ALMOST_FULL_EN
        check("async rst af", DATA_W'(almost_full), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        drive(1, 'h33, 0, 0);
        check("post-rst head", fifo_data, 'h33);
        check("post-rst count", DATA_W'(count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
